// File: rtl/bumpy_move_if.sv
// Handshake bundle between the frame/collision path and the Bumpy move controller.
// master drives frame/collision/key inputs; slave is the controller producing the position.
interface bumpy_move_if;
    logic        startOfFrame;
    logic        collision;
    logic [3:0]  HitEdgeCode;
    logic        leftKey;
    logic        rightKey;
    logic        jumpKey;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;

    modport master (
        output startOfFrame, collision, HitEdgeCode, leftKey, rightKey, jumpKey,
        input  topLeftX, topLeftY
    );

    modport slave (
        input  startOfFrame, collision, HitEdgeCode, leftKey, rightKey, jumpKey,
        output topLeftX, topLeftY
    );
endinterface

// File: rtl/bumpy_move_controller.sv
// Per-frame physics for the Bumpy character: gathers edge hits over a frame, then
// updates speeds (gravity, bounce, jump, keys) and the fixed-point top-left position.
module bumpy_move_controller #(
    parameter int INITIAL_X    = 280,
    parameter int INITIAL_Y    = 185,
    parameter int FP_SHIFT     = 6,
    parameter int X_SPEED      = 128,
    parameter int GRAVITY      = 8,
    parameter int MAX_Y_SPEED  = 512,
    parameter int BOUNCE_SPEED = 320,
    parameter int JUMP_SPEED   = 512,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int OBJECT_W     = 32,
    parameter int OBJECT_H     = 32
) (
    input  logic         clk,
    input  logic         resetN,
    bumpy_move_if.slave  bus
);

    localparam logic signed [17:0] X_INIT = 18'(INITIAL_X << FP_SHIFT);
    localparam logic signed [17:0] Y_INIT = 18'(INITIAL_Y << FP_SHIFT);
    localparam logic signed [17:0] X_MAX  = 18'((SCREEN_W - OBJECT_W) << FP_SHIFT);
    localparam logic signed [17:0] Y_MAX  = 18'((SCREEN_H - OBJECT_H) << FP_SHIFT);
    localparam logic signed [11:0] VX     = 12'(X_SPEED);
    localparam logic signed [11:0] GRAV   = 12'(GRAVITY);
    localparam logic signed [11:0] VY_MAX = 12'(MAX_Y_SPEED);
    localparam logic signed [11:0] V_BNC  = 12'(BOUNCE_SPEED);
    localparam logic signed [11:0] V_JMP  = 12'(JUMP_SPEED);

    // Edge bit positions inside HitEdgeCode.
    localparam int E_BOTTOM = 0;
    localparam int E_RIGHT  = 1;
    localparam int E_TOP    = 2;
    localparam int E_LEFT   = 3;

    typedef enum logic [1:0] {ACCUM, SPEED, POS} state_t;

    state_t             state_q, state_d;
    logic signed [17:0] x_q, x_d, y_q, y_d;
    logic signed [11:0] vx_q, vx_d, vy_q, vy_d;
    logic [3:0]         hit_acc_q, hit_acc_d;
    logic [3:0]         frame_hits_q, frame_hits_d;
    logic               pend_bottom_q, pend_bottom_d;

    logic signed [11:0] vx_n, vy_n;
    logic signed [17:0] x_sum, y_sum;

    always_comb begin
        // NOTE: every comb output and temporary gets a default first so no path infers a latch.
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        vx_d          = vx_q;
        vy_d          = vy_q;
        hit_acc_d     = hit_acc_q;
        frame_hits_d  = frame_hits_q;
        pend_bottom_d = pend_bottom_q;
        vx_n          = '0;
        vy_n          = '0;
        x_sum         = '0;
        y_sum         = '0;

        // A collision coincident with the frame pulse opens the new frame's accumulator.
        if (state_q == ACCUM && bus.startOfFrame) begin
            frame_hits_d = hit_acc_q;
            hit_acc_d    = bus.collision ? bus.HitEdgeCode : 4'b0000;
        end else if (bus.collision) begin
            hit_acc_d = hit_acc_q | bus.HitEdgeCode;
        end

        case (state_q)
            ACCUM: begin
                if (bus.startOfFrame) state_d = SPEED;
            end

            SPEED: begin
                vy_n = vy_q + GRAV;
                if (vy_n > VY_MAX) vy_n = VY_MAX;
                if ((frame_hits_q[E_BOTTOM] || pend_bottom_q) && !vy_n[11])
                    vy_n = bus.jumpKey ? -V_JMP : -V_BNC;
                if (frame_hits_q[E_TOP] && vy_n[11]) vy_n = '0;

                unique case ({bus.leftKey, bus.rightKey})
                    2'b10:   vx_n = -VX;
                    2'b01:   vx_n = VX;
                    default: vx_n = '0;
                endcase
                if (frame_hits_q[E_LEFT] && vx_n[11]) vx_n = '0;
                if (frame_hits_q[E_RIGHT] && vx_n > 12'sd0) vx_n = '0;

                vx_d          = vx_n;
                vy_d          = vy_n;
                pend_bottom_d = 1'b0;
                state_d       = POS;
            end

            POS: begin
                x_sum = x_q + $signed({{6{vx_q[11]}}, vx_q});
                y_sum = y_q + $signed({{6{vy_q[11]}}, vy_q});

                if (x_sum < 18'sd0)      x_d = '0;
                else if (x_sum > X_MAX)  x_d = X_MAX;
                else                     x_d = x_sum;

                // Landing on the floor is remembered as a bottom hit for the next frame.
                if (y_sum < 18'sd0) begin
                    y_d  = '0;
                    vy_d = '0;
                end else if (y_sum >= Y_MAX) begin
                    y_d           = Y_MAX;
                    pend_bottom_d = 1'b1;
                end else begin
                    y_d = y_sum;
                end
                state_d = ACCUM;
            end

            default: state_d = ACCUM;
        endcase
    end

    // NOTE: only a handful of scalar registers here, so all of them take the async reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ACCUM;
            x_q           <= X_INIT;
            y_q           <= Y_INIT;
            vx_q          <= '0;
            vy_q          <= '0;
            hit_acc_q     <= '0;
            frame_hits_q  <= '0;
            pend_bottom_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            vx_q          <= vx_d;
            vy_q          <= vy_d;
            hit_acc_q     <= hit_acc_d;
            frame_hits_q  <= frame_hits_d;
            pend_bottom_q <= pend_bottom_d;
        end
    end

    assign bus.topLeftX = x_q[FP_SHIFT +: 11];
    assign bus.topLeftY = y_q[FP_SHIFT +: 11];

endmodule

// File: tb/tb_bumpy_move_controller.sv
// Self-checking bench for bumpy_move_controller: directed physics scenarios plus
// randomized frames, compared against a frame-level behavioural model.
module tb_bumpy_move_controller;

    logic clk;
    logic resetN;

    bumpy_move_if bus ();

    bumpy_move_controller dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    // Frame-level model: fixed-point position/speed and the hits seen so far this frame.
    int        m_x, m_y, m_vx, m_vy;
    bit        m_pend;
    logic [3:0] m_acc;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp))
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic void model_reset();
        m_x    = 280 * 64;
        m_y    = 185 * 64;
        m_vx   = 0;
        m_vy   = 0;
        m_pend = 1'b0;
        m_acc  = 4'h0;
    endfunction

    function automatic void model_frame(input logic [3:0] hits, input bit l, r, j);
        m_vy = m_vy + 8;
        if (m_vy > 512) m_vy = 512;
        if ((hits[0] || m_pend) && m_vy >= 0) m_vy = j ? -512 : -320;
        m_pend = 1'b0;
        if (hits[2] && m_vy < 0) m_vy = 0;
        if (l && !r)      m_vx = -128;
        else if (r && !l) m_vx = 128;
        else              m_vx = 0;
        if (hits[3] && m_vx < 0) m_vx = 0;
        if (hits[1] && m_vx > 0) m_vx = 0;
        m_x = m_x + m_vx;
        if (m_x < 0)          m_x = 0;
        else if (m_x > 38912) m_x = 38912;
        m_y = m_y + m_vy;
        if (m_y < 0) begin
            m_y  = 0;
            m_vy = 0;
        end else if (m_y >= 28672) begin
            m_y    = 28672;
            m_pend = 1'b1;
        end
    endfunction

    task automatic drive_idle();
        bus.startOfFrame = 1'b0;
        bus.collision    = 1'b0;
        bus.HitEdgeCode  = 4'h0;
        bus.leftKey      = 1'b0;
        bus.rightKey     = 1'b0;
        bus.jumpKey      = 1'b0;
    endtask

    task automatic reset_dut(input string tag);
        @(negedge clk);
        drive_idle();
        resetN = 1'b0;
        #1;
        check({tag, "_x"}, 32'(bus.topLeftX), 280);
        check({tag, "_y"}, 32'(bus.topLeftY), 185);
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // One frame: pulse at cycle 0, body collisions with probability pct (code 0 = random),
    // optional extra pulses while the update is in flight.
    task automatic run_frame(input bit l, input bit r, input bit j,
                             input bit sof_col, input logic [3:0] sof_code,
                             input int pct, input logic [3:0] body_code,
                             input bit dbl_sof, input string tag);
        int         len;
        int         ox, oy;
        bit         c;
        logic [3:0] code;
        logic [3:0] hits;
        len = 4 + $urandom_range(0, 4);
        ox  = m_x / 64;
        oy  = m_y / 64;
        @(negedge clk);
        bus.leftKey      = l;
        bus.rightKey     = r;
        bus.jumpKey      = j;
        bus.startOfFrame = 1'b1;
        bus.collision    = sof_col;
        bus.HitEdgeCode  = sof_col ? sof_code : 4'($urandom);
        hits  = m_acc;
        m_acc = sof_col ? sof_code : 4'h0;
        model_frame(hits, l, r, j);
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            if (i == 2) begin
                check({tag, "_hold_x"}, 32'(bus.topLeftX), ox);
                check({tag, "_hold_y"}, 32'(bus.topLeftY), oy);
            end
            c    = ($urandom_range(0, 99) < pct);
            code = (body_code != 4'h0) ? body_code : 4'($urandom_range(1, 15));
            bus.startOfFrame = dbl_sof && (i <= 2);
            bus.collision    = c;
            bus.HitEdgeCode  = c ? code : 4'($urandom);
            if (c) m_acc = m_acc | code;
        end
        @(negedge clk);
        check({tag, "_x"}, 32'(bus.topLeftX), m_x / 64);
        check({tag, "_y"}, 32'(bus.topLeftY), m_y / 64);
        bus.startOfFrame = 1'b0;
        bus.collision    = 1'b0;
    endtask

    task automatic clean_frames(input int n, input string tag);
        for (int k = 0; k < n; k++)
            run_frame(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b0, tag);
    endtask

    initial begin
        bit floor_seen;
        bit bounce_next;
        n_checks = 0;
        n_pass   = 0;
        resetN   = 1'b0;
        drive_idle();
        model_reset();

        // Gravity only: eight frames of free fall.
        reset_dut("rst0");
        clean_frames(8, "fall");
        check("t1_y", 32'(bus.topLeftY), 189);
        check("t1_x", 32'(bus.topLeftX), 280);

        // Bottom hit while falling bounces on the following update.
        reset_dut("rst2");
        clean_frames(8, "pre2");
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 100, 4'h1, 1'b0, "hitf");
        check("t2_pre_y", 32'(bus.topLeftY), 190);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b0, "bnc");
        check("t2_bounce_y", 32'(bus.topLeftY), 185);

        // Jump only when the landing is real.
        reset_dut("rst3");
        clean_frames(8, "pre3");
        run_frame(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 100, 4'h1, 1'b0, "jnohit");
        check("t3_nojump_y", 32'(bus.topLeftY), 190);
        run_frame(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 0, 4'h0, 1'b0, "jump");
        check("t3_jump_y", 32'(bus.topLeftY), 182);

        // Horizontal keys and right-edge blocking.
        reset_dut("rst4");
        run_frame(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b0, "r1");
        check("t4_r1_x", 32'(bus.topLeftX), 282);
        run_frame(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 100, 4'h2, 1'b0, "r2");
        check("t4_r2_x", 32'(bus.topLeftX), 284);
        run_frame(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b0, "rblk");
        check("t4_blocked_x", 32'(bus.topLeftX), 284);
        run_frame(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b0, "both");
        check("t4_both_x", 32'(bus.topLeftX), 284);

        // A hit on the frame-pulse cycle belongs to the frame that pulse opens.
        reset_dut("rst6");
        run_frame(1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 0, 4'h0, 1'b0, "sofc");
        check("t6_sofhit_now_x", 32'(bus.topLeftX), 282);
        run_frame(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b0, "sofn");
        check("t6_sofhit_next_x", 32'(bus.topLeftX), 282);
        run_frame(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b0, "sofa");
        check("t6_after_x", 32'(bus.topLeftX), 284);

        // Extra frame pulses during the update are ignored.
        for (int k = 0; k < 4; k++)
            run_frame(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 20, 4'h0, 1'b1, "dbl");

        // Screen edges and floor landing.
        reset_dut("rst5");
        floor_seen  = 1'b0;
        bounce_next = 1'b0;
        for (int k = 0; k < 200 && m_x < 608 * 64; k++) begin
            run_frame(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b0, "toR");
            if (bounce_next) check("t5_bounce_y", 32'(bus.topLeftY), 443);
            bounce_next = 1'b0;
            if (!floor_seen && m_pend) begin
                floor_seen  = 1'b1;
                bounce_next = 1'b1;
                check("t5_floor_y", 32'(bus.topLeftY), 448);
            end
        end
        check("t5_right_edge", 32'(bus.topLeftX), 608);
        for (int k = 0; k < 3; k++)
            run_frame(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b0, "atR");
        check("t5_right_hold", 32'(bus.topLeftX), 608);
        for (int k = 0; k < 400 && m_x > 0; k++)
            run_frame(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b0, "toL");
        for (int k = 0; k < 3; k++)
            run_frame(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b0, "atL");
        check("t5_left_edge", 32'(bus.topLeftX), 0);

        // Reset one cycle after the frame pulse abandons the update.
        @(negedge clk);
        bus.rightKey     = 1'b1;
        bus.startOfFrame = 1'b1;
        bus.collision    = 1'b1;
        bus.HitEdgeCode  = 4'h1;
        @(negedge clk);
        drive_idle();
        resetN = 1'b0;
        #1;
        check("t6_rst_x", 32'(bus.topLeftX), 280);
        check("t6_rst_y", 32'(bus.topLeftY), 185);
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_noupd_x", 32'(bus.topLeftX), 280);
        check("t6_noupd_y", 32'(bus.topLeftY), 185);
        clean_frames(2, "postrst");

        // Randomized frames.
        for (int k = 0; k < 300; k++)
            run_frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                      4'($urandom_range(1, 15)), 15, 4'h0, ($urandom_range(0, 9) == 0), "rnd");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
